// File: rtl/ps2_key_decoder_if.sv
// Pin-level and key-level signals of the PS/2 keyboard decoder.
// The keyboard side supplies the pins; the decoder supplies the held key state.
`timescale 1ns/1ps

interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       keypressed;
  logic [7:0] scancode;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keypressed,
    input  scancode,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keypressed,
    output scancode,
    output frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the pins, deframes 11-bit frames,
// and turns make/break byte sequences into a held scancode plus a keypressed level.
`timescale 1ns/1ps

module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic            clk,
  input logic            rstn,
  ps2_key_decoder_if.slave bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // A valid frame carries an odd number of ones across data and parity.
  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

  logic           ps2c_meta_r;
  logic           ps2c_sync_r;
  logic           ps2d_meta_r;
  logic           ps2d_sync_r;
  logic [FCW-1:0] filt_cnt_r;
  logic           filt_clk_r;
  logic           filt_clk_d_r;
  logic           e_s;
  logic           frame_good_s;

  rx_state_t      state_r;
  logic [3:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic           parity_r;
  logic [TW-1:0]  tmo_cnt_r;
  logic           brk_r;
  logic           ext_r;
  logic           keypressed_r;
  logic [7:0]     scancode_r;
  logic           frame_err_r;

  // Two-flop synchronisers for both asynchronous pins, idling high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ps2c_meta_r <= 1'b1;
      ps2c_sync_r <= 1'b1;
      ps2d_meta_r <= 1'b1;
      ps2d_sync_r <= 1'b1;
    end else begin
      ps2c_meta_r <= bus.ps2_clk;
      ps2c_sync_r <= ps2c_meta_r;
      ps2d_meta_r <= bus.ps2_data;
      ps2d_sync_r <= ps2d_meta_r;
    end
  end

  // Glitch filter: the level follows the pin only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_cnt_r   <= FCW'(0);
      filt_clk_r   <= 1'b1;
      filt_clk_d_r <= 1'b1;
    end else begin
      filt_clk_d_r <= filt_clk_r;
      if (ps2c_sync_r == filt_clk_r) begin
        filt_cnt_r <= FCW'(0);
      end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
        filt_cnt_r <= FCW'(0);
        filt_clk_r <= ps2c_sync_r;
      end else begin
        filt_cnt_r <= filt_cnt_r + FCW'(1);
      end
    end
  end

  // E is the single cycle in which the filtered clock has just fallen.
  assign e_s = filt_clk_d_r & ~filt_clk_r;

  // Stop-bit acceptance: stop must be high and the data+parity ones-count odd.
  always_comb begin
    frame_good_s = 1'b0;
    if (ps2d_sync_r && odd_ones({shift_r, parity_r})) begin
      frame_good_s = 1'b1;
    end else begin
      frame_good_s = 1'b0;
    end
  end

  // Frame receiver, timeout watchdog and make/break decoder with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 4'd0;
      shift_r      <= 8'h00;
      parity_r     <= 1'b0;
      tmo_cnt_r    <= TW'(0);
      brk_r        <= 1'b0;
      ext_r        <= 1'b0;
      keypressed_r <= 1'b0;
      scancode_r   <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if ((state_r != ST_IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES))) begin
        state_r     <= ST_IDLE;
        tmo_cnt_r   <= TW'(0);
        frame_err_r <= 1'b1;
      end else if (e_s) begin
        tmo_cnt_r <= TW'(0);
        case (state_r)
          ST_IDLE: begin
            if (!ps2d_sync_r) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 4'd0;
            end
          end
          ST_DATA: begin
            shift_r   <= {ps2d_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_r <= ps2d_sync_r;
            state_r  <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (!frame_good_s) begin
              frame_err_r <= 1'b1;
            end else if (shift_r == 8'hE0) begin
              ext_r <= 1'b1;
            end else if (shift_r == 8'hF0) begin
              // An E0 F0 sequence keeps the extension flag alongside the break.
              brk_r <= 1'b1;
              ext_r <= ext_r;
            end else if (brk_r) begin
              if (shift_r == scancode_r) begin
                keypressed_r <= 1'b0;
              end
              brk_r <= 1'b0;
              ext_r <= 1'b0;
            end else begin
              scancode_r   <= shift_r;
              keypressed_r <= 1'b1;
              ext_r        <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else if (state_r != ST_IDLE) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
    end
  end

  assign bus.keypressed = keypressed_r;
  assign bus.scancode   = scancode_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed make/break table, timing and timeout corners,
// randomized byte streams against a key-state reference model, and mid-frame reset.
`timescale 1ns/1ps

module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp      = 0;
  int n_bad      = 0;
  int err_cycles = 0;

  // Every cycle with frame_err high is counted; one per dropped frame is expected.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_cycles++;
  end

  // Reference key state, derived from the make/break rules on whole bytes.
  logic       m_kp;
  logic [7:0] m_sc;
  bit         m_brk;
  int         m_drops;

  typedef struct {
    logic [7:0] b;
    bit         bp;
    bit         bs;
    logic       kp;
    logic [7:0] sc;
    int         err;
  } vec_t;

  vec_t vt[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    tick(HALF);
  endtask

  task automatic model_apply(input logic [7:0] b, input bit good);
    if (!good) begin
      m_drops++;
    end else if (b == 8'hE0) begin
      m_brk = m_brk;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_brk) begin
      if (b == m_sc) m_kp = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_sc = b;
      m_kp = 1'b1;
    end
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] b, input bit bp, input bit bs);
    send_frame(b, bp, bs);
    model_apply(b, !bp && !bs);
    chk({tag, "_kp"}, 32'(bus.keypressed), 32'(m_kp));
    chk({tag, "_sc"}, 32'(bus.scancode), 32'(m_sc));
    chk({tag, "_err"}, 32'(err_cycles), 32'(m_drops));
  endtask

  initial begin
    logic [7:0] b;
    int         base;
    int         waited;
    int         e0;
    logic [7:0] pick [4];

    vt[0]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 0};
    vt[1]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 0};
    vt[2]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 0};
    vt[3]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 0};
    vt[4]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h75, 0};
    vt[5]  = '{8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 0};
    vt[6]  = '{8'h6C, 1'b0, 1'b0, 1'b1, 8'h6C, 0};
    vt[7]  = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 0};
    vt[8]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h5A, 0};
    vt[9]  = '{8'h6C, 1'b0, 1'b0, 1'b1, 8'h5A, 0};
    vt[10] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h5A, 0};
    vt[11] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 0};
    vt[12] = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 0};
    vt[13] = '{8'h75, 1'b1, 1'b0, 1'b1, 8'h75, 1};
    vt[14] = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 2};
    vt[15] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h75, 2};
    vt[16] = '{8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 2};
    vt[17] = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 2};
    vt[18] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h75, 2};
    vt[19] = '{8'h33, 1'b1, 1'b0, 1'b1, 8'h75, 3};
    vt[20] = '{8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 3};
    vt[21] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h75, 3};
    vt[22] = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 3};
    vt[23] = '{8'hE0, 1'b0, 1'b0, 1'b1, 8'h75, 3};
    vt[24] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h75, 3};
    vt[25] = '{8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 3};

    m_kp = 1'b0; m_sc = 8'h00; m_brk = 1'b0; m_drops = 0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rstn = 1'b0;
    tick(3);
    chk("rst_kp", 32'(bus.keypressed), 32'd0);
    chk("rst_sc", 32'(bus.scancode), 32'h00);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    rstn = 1'b1;
    tick(5);

    // Exact update point: outputs move one cycle after the stop-bit sample cycle.
    b = 8'h75;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(1'b0);
    bus.ps2_data = 1'b1;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(2 + FL);
    chk("lat_before_kp", 32'(bus.keypressed), 32'd0);
    tick(1);
    chk("lat_after_kp", 32'(bus.keypressed), 32'd1);
    chk("lat_after_sc", 32'(bus.scancode), 32'h75);
    tick(HALF - 3 - FL);
    bus.ps2_clk = 1'b1;
    tick(HALF);
    chk("lat_err", 32'(err_cycles), 32'd0);
    model_apply(8'h75, 1'b1);
    frame_and_check("rel_f0", 8'hF0, 1'b0, 1'b0);
    frame_and_check("rel_75", 8'h75, 1'b0, 1'b0);

    // Directed make/break table.
    base = err_cycles;
    for (int i = 0; i < 26; i++) begin
      send_frame(vt[i].b, vt[i].bp, vt[i].bs);
      model_apply(vt[i].b, !vt[i].bp && !vt[i].bs);
      chk($sformatf("vec%0d_kp", i), 32'(bus.keypressed), 32'(vt[i].kp));
      chk($sformatf("vec%0d_sc", i), 32'(bus.scancode), 32'(vt[i].sc));
      chk($sformatf("vec%0d_err", i), 32'(err_cycles - base), 32'(vt[i].err));
    end

    // Timeout: a stalled partial frame is dropped after TMO cycles without an edge.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    e0 = err_cycles;
    waited = 0;
    while (waited < TMO + 200 && err_cycles == e0) begin
      tick(1);
      waited++;
    end
    chk("tmo_window", 32'((waited >= TMO - 2 * HALF) && (waited <= TMO + 20)), 32'd1);
    tick(5);
    m_drops++;
    chk("tmo_err", 32'(err_cycles), 32'(m_drops));
    chk("tmo_kp", 32'(bus.keypressed), 32'(m_kp));
    chk("tmo_sc", 32'(bus.scancode), 32'(m_sc));
    frame_and_check("post_tmo_69", 8'h69, 1'b0, 1'b0);
    chk("post_tmo_sc_const", 32'(bus.scancode), 32'h69);

    // Randomised byte stream against the reference model.
    pick[0] = 8'h75; pick[1] = 8'h6C; pick[2] = 8'h5A; pick[3] = 8'h29;
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      b = 8'hF0;
      else if (sel == 1) b = 8'hE0;
      else if (sel == 2) b = m_sc;
      else if (sel < 7)  b = pick[$urandom_range(0, 3)];
      else               b = 8'($urandom_range(0, 255));
      frame_and_check($sformatf("rnd%0d", n), b,
                      $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    end

    // Reset in the middle of a frame returns everything to reset values at once.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    bus.ps2_data = 1'b0;
    tick(3);
    rstn = 1'b0;
    #1;
    chk("mid_rst_kp", 32'(bus.keypressed), 32'd0);
    chk("mid_rst_sc", 32'(bus.scancode), 32'h00);
    chk("mid_rst_err", 32'(bus.frame_err), 32'd0);
    tick(2);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) ps2_bit(i[0]);
    bus.ps2_data = 1'b1;
    tick(TMO + 100);
    m_kp = 1'b0; m_sc = 8'h00; m_brk = 1'b0; m_drops = err_cycles;
    send_frame(8'h69, 1'b0, 1'b0);
    chk("after_rst_kp", 32'(bus.keypressed), 32'd1);
    chk("after_rst_sc", 32'(bus.scancode), 32'h69);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
